route_sched: RTL and testbench

//  Destination scheduler in front of the command/control block. Holds a queue of destination

---
 rtl/route_sched_pkg.sv | 32 +++
 rtl/route_fifo.sv | 89 ++++++++
 rtl/route_sched.sv | 175 +++++++++++++++++
 tb/tb_route_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/route_sched_pkg.sv
// Shared constants and types for the route scheduler and its destination FIFO.
package route_sched_pkg;

  localparam int unsigned ID_W  = 6;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned CMD_W = OP_W + ID_W;

  localparam logic [OP_W-1:0] OP_GO   = 2'b01;
  localparam logic [OP_W-1:0] OP_STOP = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ST,
    TRANSIT,
    DWELL
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [ID_W-1:0] dest;
  } cmd_t;

  // Build a command word from opcode and destination.
  function automatic cmd_t mk_cmd(input logic [OP_W-1:0] op, input logic [ID_W-1:0] dest);
    cmd_t c;
    c.op   = op;
    c.dest = dest;
    return c;
  endfunction

endpackage

// File: rtl/route_fifo.sv
// Destination-ID FIFO with flush and single-entry tail retract.
// Push is accepted when not full or when a pop happens in the same cycle.
module route_fifo
  import route_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [ID_W-1:0]        i_data,
  input  logic                   i_pop,
  input  logic                   i_retract,
  output logic [ID_W-1:0]        o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_retract;

  assign w_pop     = i_pop && !r_empty;
  assign w_push    = i_push && (!r_full || w_pop);
  assign w_retract = i_retract && !r_empty && !w_push && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if ((w_pop && !w_push) || w_retract) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end else if (w_retract) begin
          r_wr_ptr <= r_wr_ptr - PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/route_sched.sv
// Destination scheduler: queues station IDs, issues GO/STOP commands, tracks departure/arrival.
// Optional ROUTE_LOOP_EN: popped entries are re-pushed at the tail (a host push in that cycle is dropped).
module route_sched
  import route_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DWELL_CYC = 1000,
  parameter int unsigned START_TO  = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [ID_W-1:0]        i_push_id,
  input  logic                   i_abort,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [CMD_W-1:0]       o_cmd,
  output logic                   o_cmd_rdy,
  input  logic                   i_clr_cmd_rdy,
  input  logic                   i_in_transit,
  output logic                   o_busy,
  output logic                   o_arrived,
  output logic [ID_W-1:0]        o_arr_id,
  output logic                   o_err
);

  localparam int unsigned TMR_MAX = (DWELL_CYC > START_TO) ? DWELL_CYC : START_TO;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_t          r_state;
  cmd_t            r_cmd;
  logic            r_cmd_rdy;
  logic            r_arrived;
  logic            r_err;
  logic [ID_W-1:0] r_arr_id;
  logic [ID_W-1:0] r_cur_id;
  logic [TMR_W-1:0] r_timer;
  logic            r_in_transit_q;

  logic            w_empty;
  logic [ID_W-1:0] w_head;
  logic            w_pop;
  logic            w_abort_take;
  logic            w_fall;
  logic            w_start_to;
  logic            w_dwell_done;
  logic [TMR_W-1:0] w_timer_inc;
  logic            w_fifo_push;
  logic [ID_W-1:0] w_fifo_data;
  logic            w_retract;

  assign w_pop        = (r_state == IDLE) && !i_abort && !w_empty;
  assign w_abort_take = i_abort && !((r_state == ISSUE) && (r_cmd.op == OP_STOP));
  assign w_fall       = r_in_transit_q && !i_in_transit;
  assign w_start_to   = (r_timer == TMR_W'(START_TO - 1));
  assign w_dwell_done = (r_timer == TMR_W'(DWELL_CYC - 1));
  assign w_timer_inc  = (r_timer == '1) ? r_timer : r_timer + TMR_W'(1);

`ifdef ROUTE_LOOP_EN
  // Marks that the FIFO tail is still the entry re-pushed by the last pop.
  logic r_tail_own;

  assign w_retract   = r_tail_own && (r_state == WAIT_ST) && !i_abort && !i_in_transit && w_start_to;
  assign w_fifo_push = w_pop || (i_push && !w_retract);
  assign w_fifo_data = w_pop ? w_head : i_push_id;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tail_own <= 1'b0;
    end else if (i_abort) begin
      r_tail_own <= 1'b0;
    end else if (w_pop) begin
      r_tail_own <= 1'b1;
    end else if (w_retract || (i_push && !o_full)) begin
      r_tail_own <= 1'b0;
    end
  end
`else
  assign w_retract   = 1'b0;
  assign w_fifo_push = i_push;
  assign w_fifo_data = i_push_id;
`endif

  route_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_flush   (i_abort),
    .i_push    (w_fifo_push),
    .i_data    (w_fifo_data),
    .i_pop     (w_pop),
    .i_retract (w_retract),
    .o_head    (w_head),
    .o_full    (o_full),
    .o_empty   (w_empty),
    .o_count   (o_count)
  );

  // Scheduler FSM; abort preempts everything except an outstanding STOP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_cmd          <= '0;
      r_cmd_rdy      <= 1'b0;
      r_arrived      <= 1'b0;
      r_err          <= 1'b0;
      r_arr_id       <= '0;
      r_cur_id       <= '0;
      r_timer        <= '0;
      r_in_transit_q <= 1'b0;
    end else begin
      r_arrived      <= 1'b0;
      r_err          <= 1'b0;
      r_in_transit_q <= i_in_transit;
      if (w_abort_take) begin
        r_cmd     <= mk_cmd(OP_STOP, '0);
        r_cmd_rdy <= 1'b1;
        r_state   <= ISSUE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pop) begin
              r_cur_id  <= w_head;
              r_cmd     <= mk_cmd(OP_GO, w_head);
              r_cmd_rdy <= 1'b1;
              r_state   <= ISSUE;
            end
          end
          ISSUE: begin
            if (i_clr_cmd_rdy) begin
              r_cmd_rdy <= 1'b0;
              r_timer   <= '0;
              r_state   <= (r_cmd.op == OP_GO) ? WAIT_ST : IDLE;
            end
          end
          WAIT_ST: begin
            if (i_in_transit) begin
              r_state <= TRANSIT;
            end else if (w_start_to) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
          TRANSIT: begin
            if (w_fall) begin
              r_arrived <= 1'b1;
              r_arr_id  <= r_cur_id;
              r_timer   <= '0;
              r_state   <= DWELL;
            end
          end
          DWELL: begin
            if (w_dwell_done) begin
              r_state <= IDLE;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_cmd     = r_cmd;
  assign o_cmd_rdy = r_cmd_rdy;
  assign o_busy    = (r_state != IDLE);
  assign o_arrived = r_arrived;
  assign o_arr_id  = r_arr_id;
  assign o_err     = r_err;

endmodule

// File: tb/tb_route_sched.sv
// Bench for route_sched: transaction-level reference model plus directed scenarios.
module tb_route_sched;

  localparam int DEPTH = 8;
  localparam int DWELL = 40;
  localparam int STO   = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [5:0] push_id = '0;
  logic       abort = 1'b0;
  logic       clr = 1'b0;
  logic       it = 1'b0;
  logic       o_full;
  logic [3:0] o_count;
  logic [7:0] o_cmd;
  logic       o_cmd_rdy;
  logic       o_busy;
  logic       o_arrived;
  logic [5:0] o_arr_id;
  logic       o_err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  route_sched #(.DEPTH(DEPTH), .DWELL_CYC(DWELL), .START_TO(STO)) dut (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_push_id(push_id), .i_abort(abort),
    .o_full(o_full), .o_count(o_count), .o_cmd(o_cmd), .o_cmd_rdy(o_cmd_rdy),
    .i_clr_cmd_rdy(clr), .i_in_transit(it), .o_busy(o_busy), .o_arrived(o_arrived),
    .o_arr_id(o_arr_id), .o_err(o_err)
  );

  // Reference model: job-level flags and absolute-cycle deadlines.
  int         q[$];
  logic [7:0] m_cmd;
  bit         m_rdy, m_arr, m_err, m_pend, m_stop, m_await, m_move, m_dwell, m_tail;
  logic [5:0] m_arr_id, m_cur;
  int         cyc, m_due, sz0;
  bit         popped, retracted;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cmd = 8'h00; m_rdy = 0; m_arr = 0; m_err = 0; m_arr_id = '0; m_cur = '0;
      m_pend = 0; m_stop = 0; m_await = 0; m_move = 0; m_dwell = 0; m_tail = 0;
      cyc = 0; m_due = 0;
    end else begin
      cyc++;
      sz0 = q.size(); popped = 0; retracted = 0;
      m_arr = 0; m_err = 0;
      if (abort) begin q.delete(); m_tail = 0; end
      if (abort && !(m_pend && m_stop)) begin
        m_cmd = 8'h00; m_rdy = 1; m_pend = 1; m_stop = 1;
        m_await = 0; m_move = 0; m_dwell = 0;
      end else if (m_pend) begin
        if (clr) begin
          m_rdy = 0; m_pend = 0;
          if (!m_stop) begin m_await = 1; m_due = cyc + STO; end
        end
      end else if (m_await) begin
        if (it) begin
          m_await = 0; m_move = 1;
        end else if (cyc == m_due) begin
          m_err = 1; m_await = 0;
`ifdef ROUTE_LOOP_EN
          if (m_tail) begin void'(q.pop_back()); retracted = 1; end
          m_tail = 0;
`endif
        end
      end else if (m_move) begin
        if (!it) begin
          m_move = 0; m_arr = 1; m_arr_id = m_cur; m_dwell = 1; m_due = cyc + DWELL;
        end
      end else if (m_dwell) begin
        if (cyc == m_due) m_dwell = 0;
      end else if (sz0 > 0) begin
        m_cur = 6'(q.pop_front());
        m_cmd = {2'b01, m_cur}; m_rdy = 1; m_pend = 1; m_stop = 0; popped = 1;
`ifdef ROUTE_LOOP_EN
        q.push_back(int'(m_cur)); m_tail = 1;
`endif
      end
      if (push && !abort) begin
`ifdef ROUTE_LOOP_EN
        if (!popped && !retracted && sz0 < DEPTH) begin q.push_back(int'(push_id)); m_tail = 0; end
`else
        if (sz0 < DEPTH || popped) q.push_back(int'(push_id));
`endif
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (o_cmd !== m_cmd || o_cmd_rdy !== m_rdy || o_count !== 4'(q.size()) ||
          o_full !== (q.size() == DEPTH) || o_busy !== (m_pend | m_await | m_move | m_dwell) ||
          o_arrived !== m_arr || o_arr_id !== m_arr_id || o_err !== m_err) begin
        n_err++;
        $display("FAIL model t=%0t got cmd=%h rdy=%b cnt=%0d full=%b busy=%b arr=%b id=%0d err=%b want cmd=%h rdy=%b cnt=%0d busy=%b arr=%b id=%0d err=%b",
                 $time, o_cmd, o_cmd_rdy, o_count, o_full, o_busy, o_arrived, o_arr_id, o_err,
                 m_cmd, m_rdy, q.size(), (m_pend | m_await | m_move | m_dwell), m_arr, m_arr_id, m_err);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rdy(input int maxc);
    int i;
    i = 0;
    while (!o_cmd_rdy && i < maxc) begin
      @(negedge clk);
      i++;
    end
    if (!o_cmd_rdy) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_rdy: cmd_rdy=0 after %0d cycles, expected 1", maxc);
    end
  endtask

  task automatic ack();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  int exp_ids[8] = '{11, 12, 13, 14, 15, 16, 17, 21};
  int loop_ids[3] = '{1, 2, 1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_cmd", o_cmd, 8'h00);
    chk("rst_rdy", o_cmd_rdy, 0);
    chk("rst_count", o_count, 0);
    chk("rst_busy", o_busy, 0);

    // Two pushes into an idle scheduler, full trip to station 5.
    push = 1'b1; push_id = 6'd5; step(1);
    push_id = 6'd9; step(1);
    push = 1'b0;
    chk("go5_cmd", o_cmd, 8'h45);
    chk("go5_rdy", o_cmd_rdy, 1);
    chk("go5_count", o_count, 1);
    step(3);
    ack();
    chk("ack5_rdy", o_cmd_rdy, 0);
    chk("ack5_busy", o_busy, 1);
    step(10); it = 1'b1;
    step(200); it = 1'b0;
    step(1);
    chk("arr5_pulse", o_arrived, 1);
    chk("arr5_id", o_arr_id, 5);
    step(DWELL);
    chk("dwell_edge_rdy", o_cmd_rdy, 0);
    step(1);
    chk("go9_rdy", o_cmd_rdy, 1);
    chk("go9_cmd", o_cmd, 8'h49);

    // Start timeout on station 9, then 7 is dispatched.
    push = 1'b1; push_id = 6'd7; step(1); push = 1'b0;
    ack();
    chk("to_err_early", o_err, 0);
    step(STO - 1);
    chk("to_err_m1", o_err, 0);
    step(1);
    chk("to_err", o_err, 1);
    chk("to_busy", o_busy, 0);
    step(1);
    chk("go7_cmd", o_cmd, 8'h47);
    chk("go7_rdy", o_cmd_rdy, 1);

    // Abort while in transit with three queued.
    ack();
    step(2); it = 1'b1; step(2);
    push = 1'b1;
    push_id = 6'd3; step(1);
    push_id = 6'd4; step(1);
    push_id = 6'd6; step(1);
    push = 1'b0;
    chk("pre_abort_count", o_count, 3);
    abort = 1'b1; step(1); abort = 1'b0;
    chk("abort_count", o_count, 0);
    chk("abort_cmd", o_cmd, 8'h00);
    chk("abort_rdy", o_cmd_rdy, 1);
    it = 1'b0;
    ack();
    chk("stop_ack_rdy", o_cmd_rdy, 0);
    chk("stop_ack_busy", o_busy, 0);
    step(10);
    chk("post_stop_rdy", o_cmd_rdy, 0);

    // Fill to DEPTH while a GO is held, overflow drop, then push+pop at full.
    push = 1'b1; push_id = 6'd20; step(1);
    for (int i = 10; i <= 18; i++) begin
      push_id = 6'(i); step(1);
    end
    push = 1'b0;
    chk("fill_count", o_count, 8);
    chk("fill_full", o_full, 1);
    chk("fill_cmd", o_cmd, 8'h54);
    ack();
    step(STO);
    chk("fill_err", o_err, 1);
    push = 1'b1; push_id = 6'd21; step(1); push = 1'b0;
    chk("pp_count", o_count, 8);
    chk("pp_cmd", o_cmd, 8'h4A);
    for (int k = 0; k < 8; k++) begin
      ack();
      wait_rdy(STO + 10);
      chk("drain_cmd", o_cmd, {24'h0, 2'b01, 6'(exp_ids[k])});
    end
    ack();
    step(STO + 10);
    chk("drain_end_rdy", o_cmd_rdy, 0);
    chk("drain_end_count", o_count, 0);

`ifdef ROUTE_LOOP_EN
    // Looping route {1,2}; reset lands mid-ISSUE on the third GO.
    push = 1'b1; push_id = 6'd1; step(1); push = 1'b0; step(1);
    push = 1'b1; push_id = 6'd2; step(1); push = 1'b0;
    for (int t = 0; t < 3; t++) begin
      wait_rdy(DWELL + 20);
      chk("loop_cmd", o_cmd, {24'h0, 2'b01, 6'(loop_ids[t])});
      chk("loop_count", o_count, 2);
      if (t < 2) begin
        ack();
        step(2); it = 1'b1; step(3); it = 1'b0; step(1);
      end
    end
`else
    push = 1'b1; push_id = 6'd33; step(1);
    push_id = 6'd34; step(1);
    push_id = 6'd35; step(1);
    push = 1'b0;
    chk("prerst_cmd", o_cmd, 8'h61);
    chk("prerst_count", o_count, 2);
`endif
    #3 rst = 1'b1;
    #1;
    chk("midrst_rdy", o_cmd_rdy, 0);
    chk("midrst_count", o_count, 0);
    chk("midrst_cmd", o_cmd, 8'h00);
    step(2);
    rst = 1'b0;
    step(2);
    chk("postrst_rdy", o_cmd_rdy, 0);
    chk("postrst_busy", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
